// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the decode/execute datapath.
//   - Default datapath and register-address widths.
//   - ALU opcode encodings. The ALU decodes the same values.
//   - MIPS primary opcode and R-type funct values used by the decoder.
//   - Pipeline-stage state type.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // ALU opcodes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS opcode/funct decoder for the ID/EX stage.
// Ports:
//   opcode, funct : instruction fields instr[31:26] and instr[5:0]
//   alu_op        : 4-bit ALU opcode (ALU_AND for an undecodable instruction)
//   imm_sel       : 1 selects the extended immediate as operand B, 0 selects rt
//   sign_ext      : 1 sign-extends the immediate, 0 zero-extends it
//   dest_sel      : 1 writes back to rd (R-type), 0 writes back to rt
//   wen           : instruction writes a register (before the $0 check)
//   illegal       : opcode/funct not recognised
module alu_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       imm_sel,
  output logic       sign_ext,
  output logic       dest_sel,
  output logic       wen,
  output logic       illegal
);

  always_comb begin
    alu_op   = ALU_AND;
    imm_sel  = 1'b0;
    sign_ext = 1'b0;
    dest_sel = 1'b0;
    wen      = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_sel = 1'b1;
        wen      = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          default: begin
            illegal = 1'b1;
            wen     = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_LW: begin
        alu_op   = ALU_ADD;
        imm_sel  = 1'b1;
        sign_ext = 1'b1;
        wen      = 1'b1;
      end
      OP_SLTI: begin
        alu_op   = ALU_SLT;
        imm_sel  = 1'b1;
        sign_ext = 1'b1;
        wen      = 1'b1;
      end
      OP_ANDI: begin
        alu_op  = ALU_AND;
        imm_sel = 1'b1;
        wen     = 1'b1;
      end
      OP_ORI: begin
        alu_op  = ALU_OR;
        imm_sel = 1'b1;
        wen     = 1'b1;
      end
      OP_SW: begin
        // Address computation only; the store itself writes no register.
        alu_op   = ALU_ADD;
        imm_sel  = 1'b1;
        sign_ext = 1'b1;
      end
      OP_BEQ: begin
        // Branch compare: the ALU subtracts rt from rs.
        alu_op = ALU_SUB;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline stage feeding the ALU.
// Decodes opcode/funct, forwards EX/MEM and MEM/WB results onto rs/rt,
// selects operand B, and holds the result in a single-entry valid/ready
// buffer whose registers drive the ALU directly.
// Ports:
//   clk, rst                 : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready      : upstream handshake (in_ready = !out_valid | out_ready)
//   opcode, funct, imm       : instruction fields
//   rs_addr, rt_addr, rd_addr: register specifiers
//   rs_data, rt_data         : register file read data
//   flush                    : drop the held and the incoming instruction
//   exmem_* / memwb_*        : writeback ports of the later stages, used for forwarding
//   out_valid / out_ready    : downstream handshake
//   alu_op, alu_a, alu_b     : ALU opcode and operands
//   dest_addr, dest_wen      : writeback register and its enable
//   illegal                  : undecodable instruction flag
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm,
  input  logic              flush,
  input  logic              exmem_wen,
  input  logic [REG_AW-1:0] exmem_waddr,
  input  logic [DATA_W-1:0] exmem_wdata,
  input  logic              memwb_wen,
  input  logic [REG_AW-1:0] memwb_waddr,
  input  logic [DATA_W-1:0] memwb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [REG_AW-1:0] dest_addr,
  output logic              dest_wen,
  output logic              illegal
);

  // ---------------------------------------------------------------- decode
  logic [3:0] dec_alu_op;
  logic       dec_imm_sel;
  logic       dec_sign_ext;
  logic       dec_dest_sel;
  logic       dec_wen;
  logic       dec_illegal;

  alu_decode u_alu_decode (
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_alu_op),
    .imm_sel  (dec_imm_sel),
    .sign_ext (dec_sign_ext),
    .dest_sel (dec_dest_sel),
    .wen      (dec_wen),
    .illegal  (dec_illegal)
  );

  // ------------------------------------------------------------ forwarding
  // Index 0 is rs, index 1 is rt.
  logic [REG_AW-1:0] src_addr [2];
  logic [DATA_W-1:0] src_rf   [2];
  logic [DATA_W-1:0] src_fwd  [2];

  assign src_addr[0] = rs_addr;
  assign src_addr[1] = rt_addr;
  assign src_rf[0]   = rs_data;
  assign src_rf[1]   = rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      if (FWD_EN) begin : g_mux
        logic ex_hit;
        logic wb_hit;
        // $0 is hard-wired to zero, so a pending write to it never forwards.
        assign ex_hit = exmem_wen && (exmem_waddr == src_addr[gi]) && (src_addr[gi] != '0);
        assign wb_hit = memwb_wen && (memwb_waddr == src_addr[gi]) && (src_addr[gi] != '0);
        // EX/MEM holds the younger result, so it is checked first.
        assign src_fwd[gi] = ex_hit ? exmem_wdata :
                             wb_hit ? memwb_wdata : src_rf[gi];
      end else begin : g_raw
        assign src_fwd[gi] = src_rf[gi];
      end
    end
  endgenerate

  // ----------------------------------------------------- operand B / dest
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b_next;
  logic [REG_AW-1:0] dest_addr_next;
  logic              dest_wen_next;

  assign imm_ext        = dec_sign_ext ? {{(DATA_W-16){imm[15]}}, imm}
                                       : {{(DATA_W-16){1'b0}}, imm};
  assign alu_b_next     = dec_imm_sel ? imm_ext : src_fwd[1];
  assign dest_addr_next = dec_dest_sel ? rd_addr : rt_addr;
  assign dest_wen_next  = dec_wen && (dest_addr_next != '0);

  // ------------------------------------------------------- handshake FSM
  stage_state_e state_reg;
  stage_state_e state_next;
  logic         capture;

  assign out_valid = (state_reg == ST_FULL);
  assign in_ready  = (state_reg == ST_EMPTY) || out_ready;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else if (in_valid && in_ready) begin
      capture    = 1'b1;
      state_next = ST_FULL;
    end else if (out_ready) begin
      state_next = ST_EMPTY;
    end
  end

  // ----------------------------------------------------- pipeline register
  logic [3:0]        alu_op_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [REG_AW-1:0] dest_addr_reg;
  logic              dest_wen_reg;
  logic              illegal_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      alu_op_reg    <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      dest_addr_reg <= '0;
      dest_wen_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        // Data may stay stale, but a killed instruction must never write back.
        dest_wen_reg <= 1'b0;
      end else if (capture) begin
        alu_op_reg    <= dec_alu_op;
        alu_a_reg     <= src_fwd[0];
        alu_b_reg     <= alu_b_next;
        dest_addr_reg <= dest_addr_next;
        dest_wen_reg  <= dest_wen_next;
        illegal_reg   <= dec_illegal;
      end
    end
  end

  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign dest_addr = dest_addr_reg;
  assign dest_wen  = dest_wen_reg;
  assign illegal   = illegal_reg;

endmodule
